// File: rtl/usb_tx_sched.sv
// usb_tx_sched: arbitrates handshake/token/data packet sources (fixed priority
// hs > tok > data) and serialises the granted frame (SYNC, PID, payload) one bit
// per cycle towards the CRC/bit-stuff block, followed by IFG idle gap cycles.
// Ports:
//   clk, rst_n (active-HIGH async reset despite the name)
//   req_hs/req_tok/req_data, hs_pid/tok_pid/data_pid, tok_fields, data_payload : sources
//   pause : back-pressure, holds the current bit while high
//   gnt_hs/gnt_tok/gnt_data : one-cycle grants
//   s_out, start, endr, pkt_type, busy, done : serial stream and framing to the CRC block
module usb_tx_sched #(
  parameter logic [3:0] IFG = 4'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_hs,
  input  logic        req_tok,
  input  logic        req_data,
  input  logic [3:0]  hs_pid,
  input  logic [3:0]  tok_pid,
  input  logic [3:0]  data_pid,
  input  logic [10:0] tok_fields,
  input  logic [63:0] data_payload,
  input  logic        pause,
  output logic        gnt_hs,
  output logic        gnt_tok,
  output logic        gnt_data,
  output logic        s_out,
  output logic        start,
  output logic        endr,
  output logic [1:0]  pkt_type,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [1:0] PT_DATA = 2'b00;
  localparam logic [1:0] PT_TOK  = 2'b01;
  localparam logic [1:0] PT_HS   = 2'b10;

  // SYNC 0000_0001 goes out MSB first; stored LSB-first in the shifter, so the
  // single 1 lands at frame bit 7.
  localparam logic [7:0] SYNC_LSB_FIRST = 8'h80;

  logic [1:0]  state_q, state_d;
  logic [79:0] shreg_q, shreg_d;
  logic [6:0]  len_q, len_d;
  logic [6:0]  bitcnt_q, bitcnt_d;
  logic [3:0]  ifg_cnt_q, ifg_cnt_d;
  logic [1:0]  pkt_type_q, pkt_type_d;

  logic        in_idle, in_send, last_bit, gnt_any;
  logic [3:0]  sel_pid;
  logic [63:0] sel_pl;
  logic [6:0]  sel_len;
  logic [1:0]  sel_type;

  assign in_idle  = (state_q == S_IDLE);
  assign in_send  = (state_q == S_SEND);
  assign last_bit = (bitcnt_q == len_q - 7'd1);

  // Grants are combinational so they pulse in the IDLE cycle that sees the
  // request; they are masked while reset is held so nothing is granted then.
  assign gnt_hs   = in_idle & ~rst_n & req_hs;
  assign gnt_tok  = in_idle & ~rst_n & ~req_hs & req_tok;
  assign gnt_data = in_idle & ~rst_n & ~req_hs & ~req_tok & req_data;
  assign gnt_any  = gnt_hs | gnt_tok | gnt_data;

  assign s_out    = in_send & shreg_q[0];
  assign start    = in_send & (bitcnt_q == 7'd0);
  assign endr     = in_send & last_bit;
  assign done     = in_send & last_bit & ~pause;
  assign busy     = ~in_idle;
  assign pkt_type = pkt_type_q;

  // Select the fields of the winning source (priority order mirrors the grants).
  always_comb begin
    sel_pid  = data_pid;
    sel_pl   = data_payload;
    sel_len  = 7'd80;
    sel_type = PT_DATA;
    if (req_hs) begin
      sel_pid  = hs_pid;
      sel_pl   = 64'd0;
      sel_len  = 7'd16;
      sel_type = PT_HS;
    end else if (req_tok) begin
      sel_pid  = tok_pid;
      sel_pl   = {53'd0, tok_fields};
      sel_len  = 7'd27;
      sel_type = PT_TOK;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    len_d      = len_q;
    bitcnt_d   = bitcnt_q;
    ifg_cnt_d  = ifg_cnt_q;
    pkt_type_d = pkt_type_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          shreg_d    = {sel_pl, ~sel_pid, sel_pid, SYNC_LSB_FIRST};
          len_d      = sel_len;
          pkt_type_d = sel_type;
          bitcnt_d   = 7'd0;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (!pause) begin
          shreg_d = shreg_q >> 1;
          if (last_bit) begin
            bitcnt_d  = 7'd0;
            ifg_cnt_d = 4'd0;
            state_d   = (IFG == 4'd0) ? S_IDLE : S_GAP;
          end else begin
            bitcnt_d = bitcnt_q + 7'd1;
          end
        end
      end
      S_GAP: begin
        // pause is deliberately ignored here: the gap is a fixed length.
        if (ifg_cnt_q == IFG - 4'd1) begin
          ifg_cnt_d = 4'd0;
          state_d   = S_IDLE;
        end else begin
          ifg_cnt_d = (ifg_cnt_q == IFG) ? ifg_cnt_q : ifg_cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= S_IDLE;
      shreg_q    <= 80'd0;
      len_q      <= 7'd0;
      bitcnt_q   <= 7'd0;
      ifg_cnt_q  <= 4'd0;
      pkt_type_q <= PT_DATA;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      len_q      <= len_d;
      bitcnt_q   <= bitcnt_d;
      ifg_cnt_q  <= ifg_cnt_d;
      pkt_type_q <= pkt_type_d;
    end
  end

endmodule

// File: tb/tb_usb_tx_sched.sv
`timescale 1ns/1ps
module tb_usb_tx_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  localparam int GAPN = 2;

  // DUT with IFG=2
  logic        rst_n, req_hs, req_tok, req_data, pause;
  logic [3:0]  hs_pid, tok_pid, data_pid;
  logic [10:0] tok_fields;
  logic [63:0] data_payload;
  logic        gnt_hs, gnt_tok, gnt_data, s_out, start, endr, busy, done;
  logic [1:0]  pkt_type;

  // DUT with IFG=0
  logic        z_rst, z_req_hs, z_req_tok, z_req_data, z_pause;
  logic [3:0]  z_hs_pid, z_tok_pid, z_data_pid;
  logic [10:0] z_tok_fields;
  logic [63:0] z_data_payload;
  logic        z_gnt_hs, z_gnt_tok, z_gnt_data, z_s_out, z_start, z_endr, z_busy, z_done;
  logic [1:0]  z_pkt_type;

  usb_tx_sched #(.IFG(4'd2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_hs(req_hs), .req_tok(req_tok), .req_data(req_data),
    .hs_pid(hs_pid), .tok_pid(tok_pid), .data_pid(data_pid),
    .tok_fields(tok_fields), .data_payload(data_payload), .pause(pause),
    .gnt_hs(gnt_hs), .gnt_tok(gnt_tok), .gnt_data(gnt_data),
    .s_out(s_out), .start(start), .endr(endr), .pkt_type(pkt_type),
    .busy(busy), .done(done)
  );

  usb_tx_sched #(.IFG(4'd0)) dut_z (
    .clk(clk), .rst_n(z_rst),
    .req_hs(z_req_hs), .req_tok(z_req_tok), .req_data(z_req_data),
    .hs_pid(z_hs_pid), .tok_pid(z_tok_pid), .data_pid(z_data_pid),
    .tok_fields(z_tok_fields), .data_payload(z_data_payload), .pause(z_pause),
    .gnt_hs(z_gnt_hs), .gnt_tok(z_gnt_tok), .gnt_data(z_gnt_data),
    .s_out(z_s_out), .start(z_start), .endr(z_endr), .pkt_type(z_pkt_type),
    .busy(z_busy), .done(z_done)
  );

  // Reference model. Source index: 0 = handshake, 1 = token, 2 = data.
  function automatic int pkt_len(input int s);
    return (s == 0) ? 16 : (s == 1) ? 27 : 80;
  endfunction

  function automatic logic [1:0] pkt_code(input int s);
    return (s == 0) ? 2'b10 : (s == 1) ? 2'b01 : 2'b00;
  endfunction

  // Bit i of the frame as it appears on the wire.
  function automatic logic ref_bit(input logic [3:0] pid, input logic [63:0] pl, input int i);
    if (i < 7)  return 1'b0;
    if (i == 7) return 1'b1;
    if (i < 12) return pid[i-8];
    if (i < 16) return ~pid[i-12];
    return pl[i-16];
  endfunction

  task automatic scramble();
    hs_pid       = 4'($urandom);
    tok_pid      = 4'($urandom);
    data_pid     = 4'($urandom);
    tok_fields   = 11'($urandom);
    data_payload = {$urandom, $urandom};
  endtask

  // Launches one packet from source s (which must be the priority winner of
  // s plus hold), checks grant, every SEND cycle and the gap.
  // pmode: 0 no pause, 1 random pause, 2 two-cycle pauses at bits 0/40/79.
  // Entered and left just after a rising edge with the DUT in IDLE.
  task automatic test_packet(input int s, input int pmode, input logic [2:0] hold);
    logic [3:0]  pid;
    logic [63:0] pl;
    logic [2:0]  exp_g;
    logic        pz;
    int len, idx, cyc, npause, held;
    len = pkt_len(s);
    pid = 4'($urandom);
    pl  = {$urandom, $urandom};
    if (s == 1) pl = {53'd0, pl[10:0]};
    if (s == 0) pl = 64'd0;
    case (s)
      0: hs_pid = pid;
      1: begin tok_pid = pid; tok_fields = pl[10:0]; end
      default: begin data_pid = pid; data_payload = pl; end
    endcase
    exp_g = 3'b001 << s;
    {req_data, req_tok, req_hs} = hold | exp_g;
    pause = 1'b0;
    @(negedge clk);
    checks++;
    if ({gnt_data, gnt_tok, gnt_hs} !== exp_g || busy !== 1'b0 || start !== 1'b0) begin
      failures++;
      $display("FAIL grant src=%0d: gnt(d,t,h)=%b busy=%b start=%b, expected gnt=%b busy=0 start=0",
               s, {gnt_data, gnt_tok, gnt_hs}, busy, start, exp_g);
    end
    @(posedge clk); #1;
    {req_data, req_tok, req_hs} = hold;
    scramble();
    idx = 0; cyc = 0; npause = 0; held = 0;
    while (idx < len && cyc < 400) begin
      case (pmode)
        1: pz = ($urandom_range(0, 3) == 0);
        2: pz = (idx == 0 || idx == 40 || idx == 79) && held < 2;
        default: pz = 1'b0;
      endcase
      pause = pz;
      @(negedge clk);
      checks++;
      if (s_out !== ref_bit(pid, pl, idx) || start !== (idx == 0) || endr !== (idx == len-1) ||
          done !== (!pz && idx == len-1) || busy !== 1'b1 || pkt_type !== pkt_code(s) ||
          {gnt_data, gnt_tok, gnt_hs} !== 3'b000) begin
        failures++;
        $display("FAIL send src=%0d bit=%0d pause=%b: s_out=%b start=%b endr=%b done=%b busy=%b type=%b gnt=%b, expected s_out=%b start=%b endr=%b done=%b busy=1 type=%b gnt=000",
                 s, idx, pz, s_out, start, endr, done, busy, pkt_type, {gnt_data, gnt_tok, gnt_hs},
                 ref_bit(pid, pl, idx), idx == 0, idx == len-1, !pz && idx == len-1, pkt_code(s));
      end
      @(posedge clk); #1;
      scramble();
      if (pz) begin npause++; held++; end
      else begin idx++; held = 0; end
      cyc++;
    end
    pause = 1'b0;
    checks++;
    if (cyc != len + npause) begin
      failures++;
      $display("FAIL send_cycles src=%0d: got %0d cycles, expected %0d", s, cyc, len + npause);
    end
    for (int g = 0; g < GAPN; g++) begin
      pause = 1'($urandom);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || s_out !== 1'b0 || start !== 1'b0 || endr !== 1'b0 || done !== 1'b0 ||
          {gnt_data, gnt_tok, gnt_hs} !== 3'b000) begin
        failures++;
        $display("FAIL gap src=%0d cyc=%0d: busy=%b s_out=%b start=%b endr=%b done=%b gnt=%b, expected busy=1 rest 0",
                 s, g, busy, s_out, start, endr, done, {gnt_data, gnt_tok, gnt_hs});
      end
      @(posedge clk); #1;
    end
    pause = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; z_rst = 1'b1;
    {req_data, req_tok, req_hs} = 3'b111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({gnt_data, gnt_tok, gnt_hs, s_out, start, endr, busy, done} !== 8'd0 || pkt_type !== 2'b00 ||
        {z_gnt_data, z_gnt_tok, z_gnt_hs, z_s_out, z_start, z_endr, z_busy, z_done} !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs: dut=%b type=%b z=%b, expected all 0",
               {gnt_data, gnt_tok, gnt_hs, s_out, start, endr, busy, done}, pkt_type,
               {z_gnt_data, z_gnt_tok, z_gnt_hs, z_s_out, z_start, z_endr, z_busy, z_done});
    end
    @(posedge clk); #1;
    {req_data, req_tok, req_hs} = 3'b000;
    rst_n = 1'b0; z_rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_token();
    logic [26:0] gold;
    gold = 27'b00000001_10010110_10101000000;
    tok_pid = 4'b1001; tok_fields = 11'h015; req_tok = 1'b1;
    @(negedge clk);
    checks++;
    if ({gnt_data, gnt_tok, gnt_hs} !== 3'b010) begin
      failures++;
      $display("FAIL token_grant: gnt(d,t,h)=%b, expected 010", {gnt_data, gnt_tok, gnt_hs});
    end
    @(posedge clk); #1;
    req_tok = 1'b0; tok_pid = 4'b0110; tok_fields = 11'h7ea;
    for (int k = 0; k < 27; k++) begin
      @(negedge clk);
      checks++;
      if (s_out !== gold[26-k] || start !== (k == 0) || endr !== (k == 26) || done !== (k == 26) ||
          busy !== 1'b1 || pkt_type !== 2'b01) begin
        failures++;
        $display("FAIL token_bit %0d: s_out=%b start=%b endr=%b done=%b busy=%b type=%b, expected s_out=%b start=%b endr=%b done=%b busy=1 type=01",
                 k, s_out, start, endr, done, busy, pkt_type, gold[26-k], k == 0, k == 26, k == 26);
      end
      @(posedge clk); #1;
    end
    for (int g = 0; g <= GAPN; g++) begin
      @(negedge clk);
      checks++;
      if (busy !== (g < GAPN) || s_out !== 1'b0) begin
        failures++;
        $display("FAIL token_gap %0d: busy=%b s_out=%b, expected busy=%b s_out=0", g, busy, s_out, g < GAPN);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_simultaneous();
    test_packet(0, 0, 3'b110);
    test_packet(1, 0, 3'b100);
    test_packet(2, 0, 3'b000);
  endtask

  task automatic test_pause_stretch();
    test_packet(2, 2, 3'b000);
  endtask

  task automatic test_input_change();
    // test_packet rewrites every source field each cycle after the grant
    test_packet(2, 0, 3'b000);
    test_packet(1, 0, 3'b000);
  endtask

  task automatic test_reset_mid();
    logic [3:0]  pid;
    logic [63:0] pl;
    pid = 4'($urandom); pl = {$urandom, $urandom};
    data_pid = pid; data_payload = pl; req_data = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_data !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_grant: gnt_data=%b, expected 1", gnt_data);
    end
    @(posedge clk); #1;
    req_data = 1'b0;
    scramble();
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      checks++;
      if (s_out !== ref_bit(pid, pl, k)) begin
        failures++;
        $display("FAIL rstmid_bit %0d: s_out=%b, expected %b", k, s_out, ref_bit(pid, pl, k));
      end
      @(posedge clk); #1;
    end
    req_hs = 1'b1;
    rst_n = 1'b1;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      checks++;
      if ({gnt_data, gnt_tok, gnt_hs, s_out, start, endr, busy, done} !== 8'd0 || pkt_type !== 2'b00) begin
        failures++;
        $display("FAIL rstmid_outputs %0d: outs=%b type=%b, expected all 0", r,
                 {gnt_data, gnt_tok, gnt_hs, s_out, start, endr, busy, done}, pkt_type);
      end
      @(posedge clk); #1;
    end
    req_hs = 1'b0;
    rst_n = 1'b0;
    test_packet(2, 0, 3'b000);
  endtask

  task automatic test_ifg0();
    logic [3:0]  pid;
    logic [63:0] pl;
    int ph, ngnt;
    pid = 4'($urandom); pl = {53'd0, 11'($urandom)};
    z_tok_pid = pid; z_tok_fields = pl[10:0]; z_pause = 1'b0; z_req_tok = 1'b1;
    ngnt = 0;
    for (int c = 0; c < 3 * 28; c++) begin
      ph = c % 28;
      @(negedge clk);
      if (z_gnt_tok === 1'b1) ngnt++;
      checks++;
      if (z_gnt_tok !== (ph == 0) || z_start !== (ph == 1) || z_endr !== (ph == 27) ||
          z_done !== (ph == 27) || z_busy !== (ph != 0) ||
          z_s_out !== ((ph == 0) ? 1'b0 : ref_bit(pid, pl, ph - 1))) begin
        failures++;
        $display("FAIL ifg0 cyc=%0d: gnt=%b start=%b endr=%b done=%b busy=%b s_out=%b, expected gnt=%b start=%b endr=%b done=%b busy=%b",
                 c, z_gnt_tok, z_start, z_endr, z_done, z_busy, z_s_out,
                 ph == 0, ph == 1, ph == 27, ph == 27, ph != 0);
      end
      @(posedge clk); #1;
    end
    z_req_tok = 1'b0;
    checks++;
    if (ngnt != 3) begin
      failures++;
      $display("FAIL ifg0_grants: got %0d gnt_tok pulses, expected 3", ngnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [2:0] pend, m, wb;
    int w;
    pend = 3'b000;
    for (int n = 0; n < 24; n++) begin
      m = pend | 3'($urandom_range(0, 7));
      if (m == 3'b000) m = 3'b001 << $urandom_range(0, 2);
      w  = m[0] ? 0 : m[1] ? 1 : 2;
      wb = 3'b001 << w;
      test_packet(w, 1, m & ~wb);
      pend = m & ~wb;
    end
    for (int d = 0; d < 3; d++) begin
      if (pend != 3'b000) begin
        w  = pend[0] ? 0 : pend[1] ? 1 : 2;
        wb = 3'b001 << w;
        test_packet(w, 1, pend & ~wb);
        pend = pend & ~wb;
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; z_rst = 1'b1;
    {req_hs, req_tok, req_data, pause} = 4'b0000;
    {z_req_hs, z_req_tok, z_req_data, z_pause} = 4'b0000;
    hs_pid = 4'd0; tok_pid = 4'd0; data_pid = 4'd0; tok_fields = 11'd0; data_payload = 64'd0;
    z_hs_pid = 4'd0; z_tok_pid = 4'd0; z_data_pid = 4'd0; z_tok_fields = 11'd0; z_data_payload = 64'd0;
    @(posedge clk); #1;
    test_reset();
    test_token();
    test_simultaneous();
    test_pause_stretch();
    test_input_change();
    test_reset_mid();
    test_ifg0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_tx_sched.md
USB_TX_SCHED -- requirements
Module: usb_tx_sched

Interface
REQ-001 Parameter IFG, default 4'd2, sets the number of idle inter-packet gap cycles after each packet (0 means no gap).
REQ-002 clk  input  1  single clock; all logic is on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-high reset (asserted = 1).
REQ-004 req_hs, req_tok, req_data  input  1 each  level requests from the handshake, token and data packet sources.
REQ-005 hs_pid, tok_pid, data_pid  input  4 each  4-bit PID for each source.
REQ-006 tok_fields  input  11  ADDR[6:0] and ENDP[10:7] for the token.
REQ-007 data_payload  input  64  data-packet payload.
REQ-008 pause  input  1  back-pressure from the CRC/bit-stuff path; when high, the current bit is not consumed.
REQ-009 gnt_hs, gnt_tok, gnt_data  output  1 each  one-cycle grant pulses.
REQ-010 s_out  output  1  serial bit to the CRC block.
REQ-011 start, endr  output  1  first-bit and last-bit markers to the CRC block.
REQ-012 pkt_type  output  2  packet type: 2'b00 DATA, 2'b01 TOKEN, 2'b10 HSHAKE.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse when the last bit is consumed.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SEND and GAP.
REQ-016 In IDLE with any request high, the block SHALL grant one source with fixed priority hs > tok > data, and SHALL pulse that source's gnt_* in the same cycle.
REQ-017 On a grant, the block SHALL register the following on the same edge:
 - the frame into an 80-bit shift register;
 - pkt_type;
 - len: 27 for TOKEN, 80 for DATA, 16 for HSHAKE;
 - bitcnt cleared to 0;
 - the transition to SEND.
REQ-018 Frame bit order SHALL be:
 - SYNC 8'b0000_0001 sent as bits 7 down to 0;
 - then the PID byte {~pid, pid} sent LSB first;
 - then the payload LSB first (tok_fields or data_payload; none for HSHAKE).
 The CRC is not generated here.
REQ-019 Input fields SHALL be sampled only at grant; later changes SHALL NOT affect the packet in flight.
REQ-020 In SEND, s_out SHALL present the current bit, start SHALL equal (bitcnt==0), and endr SHALL equal (bitcnt==len-1).
REQ-021 In SEND with pause=0, the register SHALL shift one bit and bitcnt SHALL increment; with pause=1, s_out, start, endr and bitcnt SHALL hold.
REQ-022 When the bit at bitcnt==len-1 is consumed (pause=0), done SHALL pulse and the FSM SHALL go to GAP, or straight to IDLE if IFG==0.
REQ-023 GAP SHALL last exactly IFG cycles.
 - pause is ignored in GAP.
 - s_out, start and endr are 0 in GAP.
REQ-024 Requests SHALL be ignored outside IDLE; gnt_* SHALL never pulse in SEND or GAP.
REQ-025 A request still high when IDLE is re-entered SHALL be treated as a new request; sources deassert their request the cycle after gnt.
REQ-026 A request that drops before IDLE samples it SHALL receive no grant.
REQ-027 Latency from request to start SHALL be one cycle (request seen in IDLE, start high in the next cycle).
REQ-028 A packet of len bits with zero pauses SHALL occupy exactly len SEND cycles.
REQ-029 Each pause cycle SHALL add exactly one SEND cycle.
REQ-030 bitcnt SHALL be 7 bits wide and never exceed len-1.
REQ-031 The IFG counter SHALL be 4 bits wide and saturate at IFG.
REQ-032 At most one gnt_* SHALL be high in any cycle.
REQ-033 Outputs in IDLE SHALL be: s_out=0, start=0, endr=0, busy=0.
REQ-034 Outputs in GAP SHALL be: s_out=0, start=0, endr=0, busy=1.

Reset
REQ-035 While rst_n=1:
 - the state SHALL be IDLE;
 - all outputs SHALL be 0 (pkt_type 2'b00);
 - the shift register, bitcnt and the IFG counter SHALL be cleared.
REQ-036 Reset asserted mid-packet SHALL abort the packet immediately with no endr and no done, and SHALL leave all requests un-granted.
REQ-037 After rst_n falls, the first grant SHALL occur no earlier than the first rising edge after the fall.

Verification
REQ-038 The bench SHALL cover these directed scenarios:
 - Token, no pause: req_tok=1, tok_pid=4'b1001, tok_fields=11'h015 -> gnt_tok pulse; next 27 cycles s_out = 0000000 1, 1001 0110, 1010 1000 000; start on cycle 1, endr on cycle 27; done with endr; busy falls IFG=2 cycles later.
 - Simultaneous requests: req_hs=req_tok=req_data=1 -> gnt_hs; pkt_type=2'b10; 16 bits; after GAP, gnt_tok, then gnt_data.
 - Pause stretch: data packet with pause high on bits 0, 40 and 79 for 2 cycles each -> 86 SEND cycles; start held 3 cycles, endr held 3 cycles; bit sequence unchanged.
 - Reset mid-packet: rst_n=1 at data bit 30 -> outputs 0 in the same cycle, no done; after release, req_data yields a fresh packet from SYNC.
 - Input change after grant: data_payload altered at bit 10 -> transmitted bits match the value sampled at grant.
 - IFG=0 build with req_tok held high: back-to-back tokens; new start the cycle after done; gnt_tok pulses once per packet.
